proc_ctrl_imm_decode_stage: RTL and testbench

- Decode-stage controller that sequences the immediate generator in the 5-stage pipelined processor.
- Holds the F/D pipeline register and decodes the instruction's opcode to drive the 3-bit imm_type select into the immediate generator.
- Pipelines imm_type and validity into X under stall/squash control.
- Counts retired-into-X instructions that consumed an immediate.

---
 rtl/proc_ctrl_imm_decode_stage.sv | 102 ++++++++++
 tb/tb_proc_ctrl_imm_decode_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_imm_decode_stage.sv
// proc_ctrl_imm_decode_stage: F/D and D/X pipeline control with opcode-to-immediate-type decode and issue counter
module proc_ctrl_imm_decode_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_F,
  input  logic             val_F,
  output logic             rdy_F,
  input  logic             squash_D,
  input  logic             ostall_X,
  output logic [31:0]      inst_D,
  output logic [2:0]       imm_type_D,
  output logic             val_X,
  output logic [31:0]      inst_X,
  output logic [2:0]       imm_type_X,
  output logic             imm_used_X,
  output logic             illegal_X,
  input  logic             clr_count,
  output logic [CNT_W-1:0] imm_count
);
  logic             r_val_D;
  logic [31:0]      r_inst_D;
  logic             r_val_X;
  logic [31:0]      r_inst_X;
  logic [2:0]       r_type_X;
  logic             r_used_X;
  logic             r_ill_X;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_type;
  logic             w_used;
  logic             w_ill;
  logic             w_stall_D;
  logic             w_issue;

  always_comb begin
    w_type = 3'd0;
    w_used = 1'b1;
    w_ill  = 1'b0;
    case (r_inst_D[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: w_type = 3'd0;
      7'b0100011: w_type = 3'd1;
      7'b1100011: w_type = 3'd2;
      7'b0110111, 7'b0010111: w_type = 3'd3;
      7'b1101111: w_type = 3'd4;
      7'b0110011: w_used = 1'b0;
      default: begin
        w_used = 1'b0;
        w_ill  = 1'b1;
      end
    endcase
  end

  assign w_stall_D = r_val_D & ostall_X;
  assign w_issue   = r_val_D & ~squash_D & ~ostall_X;

  // squash outranks stall so a killed instruction cannot linger in D
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val_D  <= 1'b0;
      r_inst_D <= NOP_INST;
    end else if (squash_D) begin
      r_val_D <= 1'b0;
    end else if (!w_stall_D) begin
      r_val_D <= val_F;
      if (val_F) r_inst_D <= inst_F;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val_X  <= 1'b0;
      r_inst_X <= NOP_INST;
      r_type_X <= 3'd0;
      r_used_X <= 1'b0;
      r_ill_X  <= 1'b0;
    end else if (!ostall_X) begin
      r_val_X  <= r_val_D & ~squash_D;
      r_inst_X <= r_inst_D;
      r_type_X <= w_type;
      r_used_X <= w_used;
      r_ill_X  <= w_ill & r_val_D & ~squash_D;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else if (clr_count) r_cnt <= '0;
    else if (w_issue && w_used && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
  end

  assign rdy_F      = ~w_stall_D;
  assign inst_D     = r_inst_D;
  assign imm_type_D = w_type;
  assign val_X      = r_val_X;
  assign inst_X     = r_inst_X;
  assign imm_type_X = r_type_X;
  assign imm_used_X = r_used_X;
  assign illegal_X  = r_ill_X;
  assign imm_count  = r_cnt;
endmodule

// File: tb/tb_proc_ctrl_imm_decode_stage.sv
// tb_proc_ctrl_imm_decode_stage: directed vectors for the decode-stage controller (4-bit counter instance)
module tb_proc_ctrl_imm_decode_stage;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] SW    = 32'h00112023;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] JAL   = 32'h0080006F;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] ILL   = 32'h0000007F;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      inst_F = '0;
  logic             val_F = 1'b0;
  logic             rdy_F;
  logic             squash_D = 1'b0;
  logic             ostall_X = 1'b0;
  logic [31:0]      inst_D;
  logic [2:0]       imm_type_D;
  logic             val_X;
  logic [31:0]      inst_X;
  logic [2:0]       imm_type_X;
  logic             imm_used_X;
  logic             illegal_X;
  logic             clr_count = 1'b0;
  logic [CNT_W-1:0] imm_count;
  int               n_cmp = 0;
  int               n_err = 0;

  proc_ctrl_imm_decode_stage #(.CNT_W(CNT_W), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .inst_F(inst_F), .val_F(val_F), .rdy_F(rdy_F),
    .squash_D(squash_D), .ostall_X(ostall_X), .inst_D(inst_D), .imm_type_D(imm_type_D),
    .val_X(val_X), .inst_X(inst_X), .imm_type_X(imm_type_X), .imm_used_X(imm_used_X),
    .illegal_X(illegal_X), .clr_count(clr_count), .imm_count(imm_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic vf, input logic [31:0] inst, input logic sq, input logic st, input logic clr);
    val_F = vf;
    inst_F = inst;
    squash_D = sq;
    ostall_X = st;
    clr_count = clr;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep [6] = '{ADDI, SW, BEQ, LUI, JAL, ADD};
  logic [2:0]  typ   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic        used  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #12;
    check("rst_val_X", 32'(val_X), 32'd0);
    check("rst_inst_X", inst_X, NOP);
    check("rst_inst_D", inst_D, NOP);
    check("rst_type_X", 32'(imm_type_X), 32'd0);
    check("rst_ill_X", 32'(illegal_X), 32'd0);
    check("rst_cnt", 32'(imm_count), 32'd0);
    check("rst_rdy_F", 32'(rdy_F), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(i < 6, i < 6 ? sweep[i] : 32'h0, 1'b0, 1'b0, 1'b0);
      if (i < 6) check($sformatf("sweep_type_D%0d", i), 32'(imm_type_D), 32'(typ[i]));
      if (i >= 1 && i <= 6) begin
        check($sformatf("sweep_val_X%0d", i - 1), 32'(val_X), 32'd1);
        check($sformatf("sweep_inst_X%0d", i - 1), inst_X, sweep[i-1]);
        check($sformatf("sweep_type_X%0d", i - 1), 32'(imm_type_X), 32'(typ[i-1]));
        check($sformatf("sweep_used_X%0d", i - 1), 32'(imm_used_X), 32'(used[i-1]));
      end
    end
    check("sweep_bubble_val_X", 32'(val_X), 32'd0);
    check("sweep_cnt", 32'(imm_count), 32'd5);

    step(1'b1, ADDI, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, SW, 1'b0, 1'b1, 1'b0);
      check("stall_rdy_F", 32'(rdy_F), 32'd0);
      check("stall_inst_D", inst_D, ADDI);
      check("stall_val_X", 32'(val_X), 32'd0);
      check("stall_inst_X", inst_X, ADD);
      check("stall_cnt", 32'(imm_count), 32'd5);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("unstall_val_X", 32'(val_X), 32'd1);
    check("unstall_inst_X", inst_X, ADDI);
    check("unstall_cnt", 32'(imm_count), 32'd6);

    step(1'b1, BEQ, 1'b0, 1'b0, 1'b0);
    check("sq_pre_inst_D", inst_D, BEQ);
    step(1'b1, LUI, 1'b1, 1'b0, 1'b0);
    check("sq_inst_D_held", inst_D, BEQ);
    check("sq_rdy_F", 32'(rdy_F), 32'd1);
    check("sq_val_X", 32'(val_X), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sq_after_val_X", 32'(val_X), 32'd0);
    check("sq_cnt", 32'(imm_count), 32'd6);

    step(1'b1, ILL, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("ill_illegal_X", 32'(illegal_X), 32'd1);
    check("ill_val_X", 32'(val_X), 32'd1);
    check("ill_used_X", 32'(imm_used_X), 32'd0);
    check("ill_cnt", 32'(imm_count), 32'd6);
    step(1'b1, ILL, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("illsq_illegal_X", 32'(illegal_X), 32'd0);
    check("illsq_val_X", 32'(val_X), 32'd0);

    for (int i = 0; i < 20; i++) step(1'b1, ADDI, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt", 32'(imm_count), 32'd15);
    step(1'b1, ADDI, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("clr_val_X", 32'(val_X), 32'd1);
    check("clr_cnt", 32'(imm_count), 32'd0);

    step(1'b1, ADDI, 1'b0, 1'b0, 1'b0);
    step(1'b1, ADDI, 1'b0, 1'b0, 1'b0);
    step(1'b1, SW, 1'b0, 1'b1, 1'b0);
    check("prerst_cnt", 32'(imm_count), 32'd1);
    check("prerst_val_X", 32'(val_X), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_val_X", 32'(val_X), 32'd0);
    check("arst_inst_X", inst_X, NOP);
    check("arst_inst_D", inst_D, NOP);
    check("arst_rdy_F", 32'(rdy_F), 32'd1);
    check("arst_cnt", 32'(imm_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, SW, 1'b0, 1'b0, 1'b0);
    check("rel_inst_D", inst_D, SW);
    check("rel_type_D", 32'(imm_type_D), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rel_val_X", 32'(val_X), 32'd1);
    check("rel_type_X", 32'(imm_type_X), 32'd1);
    check("rel_cnt", 32'(imm_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
